// File: rtl/flit_link_tx.sv
// Credit-based link transmitter: packs flits, stages them in a small FIFO
// and writes them into a downstream buffer while credits remain.
module flit_link_tx #(
    parameter int BUF_DEPTH = 7,
    parameter int CRED_W    = 3,
    parameter int Q_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       src_data,
    input  logic [3:0]        src_addr,
    input  logic [2:0]        src_target,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [22:0]       tx_data,
    output logic              tx_valid,
    input  logic              credit_return,
    output logic [CRED_W-1:0] credits,
    output logic              cred_err
);

    localparam int FW = 23;
    localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CW = $clog2(Q_DEPTH + 1);
    localparam logic [PW-1:0]     P_LAST = PW'(Q_DEPTH - 1);
    localparam logic [PW-1:0]     P_ONE  = PW'(1);
    localparam logic [CW-1:0]     C_FULL = CW'(Q_DEPTH);
    localparam logic [CW-1:0]     C_ONE  = CW'(1);
    localparam logic [CRED_W-1:0] K_MAX  = CRED_W'(BUF_DEPTH);
    localparam logic [CRED_W-1:0] K_ONE  = CRED_W'(1);

    logic [FW-1:0]     r_mem [Q_DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_cnt;
    logic [CRED_W-1:0] r_cred;
    logic              r_err;
    logic              r_tx_valid;
    logic [FW-1:0]     r_tx_data;

    logic [FW-1:0]     w_flit;
    logic              w_push;
    logic              w_send;
    logic              w_ovf;
    logic [CRED_W-1:0] w_cred_nxt;
    logic [CW-1:0]     w_cnt_nxt;

    assign w_flit    = {src_data, src_addr, src_target};
    assign src_ready = (r_cnt < C_FULL);
    assign w_push    = src_valid & src_ready;
    assign w_send    = (r_cnt != '0) & (r_cred != '0);
    assign w_ovf     = credit_return & (r_cred == K_MAX);

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign credits  = r_cred;
    assign cred_err = r_err;

    // Next credit value: a return into an empty downstream buffer saturates.
    always_comb begin
        w_cred_nxt = r_cred;
        if (w_ovf) begin
            w_cred_nxt = K_MAX;
        end else if (w_send & ~credit_return) begin
            w_cred_nxt = r_cred - K_ONE;
        end else if (credit_return & ~w_send) begin
            w_cred_nxt = r_cred + K_ONE;
        end
    end

    // Next queue occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_push, w_send})
            2'b10:   w_cnt_nxt = r_cnt + C_ONE;
            2'b01:   w_cnt_nxt = r_cnt - C_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Queue storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_flit;
        end
    end

    // Queue pointers, occupancy, credits and the sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_cred <= K_MAX;
            r_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == P_LAST) ? '0 : r_wr + P_ONE;
            end
            if (w_send) begin
                r_rd <= (r_rd == P_LAST) ? '0 : r_rd + P_ONE;
            end
            r_cnt  <= w_cnt_nxt;
            r_cred <= w_cred_nxt;
            if (w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    // Downstream write port: head flit on a send, zeros otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_send) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_mem[r_rd];
        end else begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end
    end

endmodule
